// File: rtl/ctrl_pkg.sv
// Decoder control-bundle layout shared by ID/EX and downstream stages.
// Bit indices name individual control lines inside the 14-bit bundle.
package ctrl_pkg;

  localparam int CTRL_W = 14;

  localparam int RegDest      = 13;
  localparam int BranchEQ     = 12;
  localparam int BranchNE     = 11;
  localparam int MemRead      = 10;
  localparam int MemToReg     = 9;
  localparam int ALUOp1       = 8;
  localparam int ALUOp2       = 7;
  localparam int MemWrite     = 6;
  localparam int ALUSrc       = 5;
  localparam int RegWrite     = 4;
  localparam int Jump         = 3;
  localparam int TrunkModeHi  = 2;
  localparam int TrunkModeLo  = 1;
  localparam int ShiftToTrunk = 0;

  localparam logic [1:0] TRUNK_WORD = 2'b00;
  localparam logic [1:0] TRUNK_HALF = 2'b01;
  localparam logic [1:0] TRUNK_BYTE = 2'b10;

  typedef logic [CTRL_W-1:0] ctrl_t;

endpackage

// File: rtl/id_ex_stage_if.sv
// ID-side inputs and EX-side outputs of the ID/EX pipeline register.
// The stage owns the slave view; the decoder/EX side uses master.
interface id_ex_stage_if
  import ctrl_pkg::*;
#(
  parameter int DATA_W = 32
);
  logic              id_valid;
  ctrl_t             id_ctrl;
  logic [31:0]       id_pc_plus4;
  logic [DATA_W-1:0] id_rs_data;
  logic [DATA_W-1:0] id_rt_data;
  logic [15:0]       id_imm;
  logic [4:0]        id_rs;
  logic [4:0]        id_rt;
  logic [4:0]        id_rd;

  ctrl_t             ex_ctrl;
  logic              ex_valid;
  logic [31:0]       ex_pc_plus4;
  logic [DATA_W-1:0] ex_rs_data;
  logic [DATA_W-1:0] ex_rt_data;
  logic [DATA_W-1:0] ex_imm_ext;
  logic [4:0]        ex_rs;
  logic [4:0]        ex_rt;
  logic [4:0]        ex_rd;

  modport slave (
    input  id_valid, id_ctrl, id_pc_plus4, id_rs_data, id_rt_data,
           id_imm, id_rs, id_rt, id_rd,
    output ex_ctrl, ex_valid, ex_pc_plus4, ex_rs_data, ex_rt_data,
           ex_imm_ext, ex_rs, ex_rt, ex_rd
  );

  modport master (
    output id_valid, id_ctrl, id_pc_plus4, id_rs_data, id_rt_data,
           id_imm, id_rs, id_rt, id_rd,
    input  ex_ctrl, ex_valid, ex_pc_plus4, ex_rs_data, ex_rt_data,
           ex_imm_ext, ex_rs, ex_rt, ex_rd
  );
endinterface

// File: rtl/load_use_detect.sv
// Combinational load-use compare: a load in EX whose destination is read
// by the instruction in ID.
module load_use_detect (
  input  logic       exValid,
  input  logic       exMemRead,
  input  logic [4:0] exRt,
  input  logic       idValid,
  input  logic       idJump,
  input  logic       idRegDest,
  input  logic       idBranchEQ,
  input  logic       idBranchNE,
  input  logic       idMemWrite,
  input  logic [4:0] idRs,
  input  logic [4:0] idRt,
  output logic       hazard
);
  logic usesRs;
  logic usesRt;
  logic loadInEx;

  assign usesRs   = ~idJump;
  assign usesRt   = idRegDest | idBranchEQ | idBranchNE | idMemWrite;
  // $0 is never a real dependency, even when a load targets it
  assign loadInEx = exValid & exMemRead & (exRt != 5'd0) & idValid;

  assign hazard = loadInEx &
                  ((usesRs & (idRs == exRt)) | (usesRt & (idRt == exRt)));
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush kill and a
// saturating count of hazard-stall cycles.
module id_ex_stage
  import ctrl_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   hold,
  input  logic                   flush,
  id_ex_stage_if.slave           bus,
  output logic                   stall,
  output logic [STALL_CNT_W-1:0] stall_count
);

  function automatic logic [STALL_CNT_W-1:0] satInc(input logic [STALL_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  ctrl_t                    ctrl_p1;
  logic                     vld_p1;
  logic [31:0]              pc_p1;
  logic signed [DATA_W-1:0] rsData_p1;
  logic signed [DATA_W-1:0] rtData_p1;
  logic signed [DATA_W-1:0] immExt_p1;
  logic [4:0]               rs_p1;
  logic [4:0]               rt_p1;
  logic [4:0]               rd_p1;
  logic [STALL_CNT_W-1:0]   stallCnt;

  logic                     hazard;
  logic signed [DATA_W-1:0] immExt;

  load_use_detect u_detect (
    .exValid   (vld_p1),
    .exMemRead (ctrl_p1[MemRead]),
    .exRt      (rt_p1),
    .idValid   (bus.id_valid),
    .idJump    (bus.id_ctrl[Jump]),
    .idRegDest (bus.id_ctrl[RegDest]),
    .idBranchEQ(bus.id_ctrl[BranchEQ]),
    .idBranchNE(bus.id_ctrl[BranchNE]),
    .idMemWrite(bus.id_ctrl[MemWrite]),
    .idRs      (bus.id_rs),
    .idRt      (bus.id_rt),
    .hazard    (hazard)
  );

  assign immExt = DATA_W'($signed(bus.id_imm));
  assign stall  = hazard & ~flush & ~hold;

  // ID -> EX boundary
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_p1   <= '0;
      vld_p1    <= 1'b0;
      pc_p1     <= '0;
      rsData_p1 <= '0;
      rtData_p1 <= '0;
      immExt_p1 <= '0;
      rs_p1     <= '0;
      rt_p1     <= '0;
      rd_p1     <= '0;
      stallCnt  <= '0;
    end else if (!hold) begin
      pc_p1     <= bus.id_pc_plus4;
      rsData_p1 <= bus.id_rs_data;
      rtData_p1 <= bus.id_rt_data;
      immExt_p1 <= immExt;
      rs_p1     <= bus.id_rs;
      rt_p1     <= bus.id_rt;
      rd_p1     <= bus.id_rd;
      // a killed or bubbled slot carries all-zero control so nothing commits
      if (flush || hazard) begin
        ctrl_p1 <= '0;
        vld_p1  <= 1'b0;
      end else begin
        ctrl_p1 <= bus.id_valid ? bus.id_ctrl : '0;
        vld_p1  <= bus.id_valid;
      end
      if (!flush && hazard)
        stallCnt <= satInc(stallCnt);
    end
  end

  assign bus.ex_ctrl     = ctrl_p1;
  assign bus.ex_valid    = vld_p1;
  assign bus.ex_pc_plus4 = pc_p1;
  assign bus.ex_rs_data  = rsData_p1;
  assign bus.ex_rt_data  = rtData_p1;
  assign bus.ex_imm_ext  = immExt_p1;
  assign bus.ex_rs       = rs_p1;
  assign bus.ex_rt       = rt_p1;
  assign bus.ex_rd       = rd_p1;
  assign stall_count     = stallCnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed-vector bench for id_ex_stage: pass-through, load-use bubbles,
// flush priority, hold, counter saturation and asynchronous reset.
module tb_id_ex_stage;
  import ctrl_pkg::*;

  // narrow counter so saturation is reachable in a short run
  localparam int CW = 4;
  localparam logic [CW-1:0] CNT_MAX = '1;

  localparam logic [13:0] C_ADDI  = 14'h0030;
  localparam logic [13:0] C_LW    = 14'h0630;
  localparam logic [13:0] C_RTYPE = 14'h2110;

  logic          clk = 1'b0;
  logic          reset;
  logic          hold;
  logic          flush;
  logic          stall;
  logic [CW-1:0] stall_count;

  int checks = 0;
  int failures = 0;

  id_ex_stage_if #(.DATA_W(32)) bus ();

  id_ex_stage #(.DATA_W(32), .STALL_CNT_W(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .hold       (hold),
    .flush      (flush),
    .bus        (bus),
    .stall      (stall),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [13:0] c, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd,
                       input logic [15:0] imm, input logic [31:0] rsd,
                       input logic [31:0] rtd, input logic [31:0] pc);
    bus.id_valid    = v;
    bus.id_ctrl     = c;
    bus.id_rs       = rs;
    bus.id_rt       = rt;
    bus.id_rd       = rd;
    bus.id_imm      = imm;
    bus.id_rs_data  = rsd;
    bus.id_rt_data  = rtd;
    bus.id_pc_plus4 = pc;
  endtask

  initial begin
    reset = 1'b1;
    hold  = 1'b0;
    flush = 1'b0;
    drive(1'b0, '0, '0, '0, '0, '0, '0, '0, '0);
    step();
    step();
    checkVal("rst_ctrl",  32'(bus.ex_ctrl), 32'h0);
    checkVal("rst_valid", 32'(bus.ex_valid), 32'h0);
    checkVal("rst_cnt",   32'(stall_count), 32'h0);
    checkVal("rst_stall", 32'(stall), 32'h0);
    reset = 1'b0;

    // pass-through with negative immediate
    drive(1'b1, C_ADDI, 5'd3, 5'd8, 5'd0, 16'h8000, 32'h12345678, 32'hCAFEBABE, 32'h00400004);
    step();
    checkVal("pt_imm",   bus.ex_imm_ext, 32'hFFFF8000);
    checkVal("pt_rsd",   bus.ex_rs_data, 32'h12345678);
    checkVal("pt_rtd",   bus.ex_rt_data, 32'hCAFEBABE);
    checkVal("pt_pc",    bus.ex_pc_plus4, 32'h00400004);
    checkVal("pt_ctrl",  32'(bus.ex_ctrl), 32'(C_ADDI));
    checkVal("pt_valid", 32'(bus.ex_valid), 32'h1);
    checkVal("pt_rs",    32'(bus.ex_rs), 32'd3);
    checkVal("pt_rt",    32'(bus.ex_rt), 32'd8);

    // load-use on rt
    drive(1'b1, C_LW, 5'd29, 5'd8, 5'd0, 16'h7FFF, 32'h1000, 32'h0, 32'h00400008);
    step();
    checkVal("lw_imm", bus.ex_imm_ext, 32'h00007FFF);
    drive(1'b1, C_RTYPE, 5'd9, 5'd8, 5'd10, 16'h5020, 32'h9, 32'h8, 32'h0040000C);
    #1;
    checkVal("lu_stall", 32'(stall), 32'h1);
    step();
    checkVal("lu_bub_ctrl",  32'(bus.ex_ctrl), 32'h0);
    checkVal("lu_bub_valid", 32'(bus.ex_valid), 32'h0);
    checkVal("lu_cnt",       32'(stall_count), 32'd1);
    checkVal("lu_stall_clr", 32'(stall), 32'h0);
    step();
    checkVal("lu_rt_ctrl", 32'(bus.ex_ctrl), 32'(C_RTYPE));
    checkVal("lu_rt_rd",   32'(bus.ex_rd), 32'd10);
    checkVal("lu_cnt2",    32'(stall_count), 32'd1);

    // load to $0 is not a dependency
    drive(1'b1, C_LW, 5'd29, 5'd0, 5'd0, 16'h0, 32'h0, 32'h0, 32'h0);
    step();
    drive(1'b1, C_RTYPE, 5'd0, 5'd0, 5'd11, 16'h0, 32'h0, 32'h0, 32'h0);
    #1;
    checkVal("z0_stall", 32'(stall), 32'h0);
    step();
    checkVal("z0_ctrl", 32'(bus.ex_ctrl), 32'(C_RTYPE));

    // ADDI does not read rt
    drive(1'b1, C_LW, 5'd29, 5'd8, 5'd0, 16'h0, 32'h0, 32'h0, 32'h0);
    step();
    drive(1'b1, C_ADDI, 5'd9, 5'd8, 5'd0, 16'h1, 32'h0, 32'h0, 32'h0);
    #1;
    checkVal("addi_rt_stall", 32'(stall), 32'h0);
    step();
    checkVal("addi_rt_ctrl", 32'(bus.ex_ctrl), 32'(C_ADDI));

    // ADDI does read rs
    drive(1'b1, C_LW, 5'd29, 5'd8, 5'd0, 16'h0, 32'h0, 32'h0, 32'h0);
    step();
    drive(1'b1, C_ADDI, 5'd8, 5'd9, 5'd0, 16'h1, 32'h0, 32'h0, 32'h0);
    #1;
    checkVal("addi_rs_stall", 32'(stall), 32'h1);
    step();
    checkVal("addi_rs_cnt", 32'(stall_count), 32'd2);

    // flush beats hazard
    drive(1'b1, C_LW, 5'd29, 5'd8, 5'd0, 16'h0, 32'h0, 32'h0, 32'h0);
    step();
    drive(1'b1, C_RTYPE, 5'd9, 5'd8, 5'd12, 16'h0, 32'h0, 32'h0, 32'h0);
    flush = 1'b1;
    #1;
    checkVal("fl_stall", 32'(stall), 32'h0);
    step();
    flush = 1'b0;
    checkVal("fl_ctrl",  32'(bus.ex_ctrl), 32'h0);
    checkVal("fl_valid", 32'(bus.ex_valid), 32'h0);
    checkVal("fl_cnt",   32'(stall_count), 32'd2);

    // hold freezes everything, even with a live hazard
    drive(1'b1, C_LW, 5'd29, 5'd8, 5'd0, 16'h0, 32'h11111111, 32'h0, 32'h0);
    step();
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, C_RTYPE, 5'd9, 5'd8, 5'(13 + i), 16'(i), 32'(i), 32'h0, 32'h0);
      #1;
      checkVal("hold_stall", 32'(stall), 32'h0);
      step();
      checkVal("hold_ctrl", 32'(bus.ex_ctrl), 32'(C_LW));
      checkVal("hold_rsd",  bus.ex_rs_data, 32'h11111111);
    end
    checkVal("hold_cnt", 32'(stall_count), 32'd2);
    hold = 1'b0;

    // repeated hazards drive the counter into saturation
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, C_LW, 5'd29, 5'd8, 5'd0, 16'h0, 32'h0, 32'h0, 32'h0);
      step();
      drive(1'b1, C_RTYPE, 5'd9, 5'd8, 5'd10, 16'h0, 32'h0, 32'h0, 32'h0);
      step();
    end
    checkVal("sat_cnt", 32'(stall_count), 32'(CNT_MAX));
    drive(1'b1, C_LW, 5'd29, 5'd8, 5'd0, 16'h0, 32'h0, 32'h0, 32'h0);
    step();
    drive(1'b1, C_RTYPE, 5'd9, 5'd8, 5'd10, 16'h0, 32'h0, 32'h0, 32'h0);
    step();
    checkVal("sat_hold", 32'(stall_count), 32'(CNT_MAX));

    // asynchronous reset in the middle of a stall
    drive(1'b1, C_LW, 5'd29, 5'd8, 5'd0, 16'h0, 32'hDEADBEEF, 32'h0, 32'h0);
    step();
    drive(1'b1, C_RTYPE, 5'd9, 5'd8, 5'd10, 16'h0, 32'h0, 32'h0, 32'h0);
    #1;
    checkVal("mr_pre_stall", 32'(stall), 32'h1);
    reset = 1'b1;
    #1;
    checkVal("mr_ctrl",  32'(bus.ex_ctrl), 32'h0);
    checkVal("mr_valid", 32'(bus.ex_valid), 32'h0);
    checkVal("mr_rsd",   bus.ex_rs_data, 32'h0);
    checkVal("mr_stall", 32'(stall), 32'h0);
    checkVal("mr_cnt",   32'(stall_count), 32'h0);
    step();
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
